// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: operand/result valid-ready bundle for the bit-serial subtractor.
interface serial_subtractor_if #(parameter int WIDTH = 4);
    logic             in_valid, in_ready, bin, out_valid, out_ready, bout, ovf;
    logic [WIDTH-1:0] a, b, diff;
    modport master(output in_valid, a, b, bin, out_ready, input in_ready, out_valid, diff, bout, ovf);
    modport slave(input in_valid, a, b, bin, out_ready, output in_ready, out_valid, diff, bout, ovf);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one bit per clock behind valid/ready handshakes.
module serial_subtractor #(parameter int WIDTH = 4) (
    input logic clk,
    input logic rst_n,
    serial_subtractor_if.slave io
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
    logic             br_q, br_d, bout_q, bout_d, amsb_q, amsb_d, bmsb_q, bmsb_d;
    logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic             d_bit, br_next;
    assign d_bit   = a_q[0] ^ b_q[0] ^ br_q;
    assign br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        diff_d      = diff_q;
        br_d        = br_q;
        bout_d      = bout_q;
        amsb_d      = amsb_q;
        bmsb_d      = bmsb_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: if (io.in_valid) begin
                a_d        = io.a;
                b_d        = io.b;
                br_d       = io.bin;
                amsb_d     = io.a[WIDTH-1];
                bmsb_d     = io.b[WIDTH-1];
                cnt_d      = '0;
                in_ready_d = 1'b0;
                state_d    = RUN;
            end
            RUN: begin
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                br_d   = br_next;
                diff_d = {d_bit, diff_q[WIDTH-1:1]};
                // Counter stops at the last bit instead of wrapping
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d     = HOLD;
                    bout_d      = br_next;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: if (io.out_ready) begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            br_q        <= 1'b0;
            bout_q      <= 1'b0;
            amsb_q      <= 1'b0;
            bmsb_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            diff_q      <= diff_d;
            br_q        <= br_d;
            bout_q      <= bout_d;
            amsb_q      <= amsb_d;
            bmsb_q      <= bmsb_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end
    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.diff      = diff_q;
    assign io.bout      = bout_q;
    assign io.ovf       = (amsb_q ^ bmsb_q) & (diff_q[WIDTH-1] ^ amsb_q);
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vectors against an arithmetic reference model of the serial subtractor.
module tb_serial_subtractor;
    localparam int W = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;
    serial_subtractor_if #(.WIDTH(W)) intf();
    serial_subtractor #(.WIDTH(W)) dut(.clk(clk), .rst_n(rst_n), .io(intf));
    int checks = 0, errors = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    // Returns {ovf, bout, diff} from plain integer arithmetic
    function automatic logic [W+1:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] f;
        int r;
        f = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
        r = int'($signed(x)) - int'($signed(y)) - int'(c);
        return {(r < -(2 ** (W - 1))) || (r > 2 ** (W - 1) - 1), f};
    endfunction
    logic         m_busy, m_bout, m_ovf;
    int           m_el;
    logic [W-1:0] m_diff;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_el   <= 0;
        end else if (m_busy) begin
            m_el <= m_el + 1;
            if (m_el >= W && intf.out_ready) m_busy <= 1'b0;
        end else if (intf.in_valid) begin
            m_busy <= 1'b1;
            m_el   <= 0;
            {m_ovf, m_bout, m_diff} <= ref_sub(intf.a, intf.b, intf.bin);
        end
    end
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", intf.in_ready, !m_busy);
            chk("out_valid", intf.out_valid, m_busy && m_el >= W);
            if (m_busy && m_el >= W) begin
                chk("diff", intf.diff, m_diff);
                chk("bout", intf.bout, m_bout);
                chk("ovf", intf.ovf, m_ovf);
            end
        end
    end
    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic tc,
                      input logic [W-1:0] ed, input logic eb, input logic eo, input int hold, input string nm);
        int n;
        intf.a = ta; intf.b = tb2; intf.bin = tc; intf.in_valid = 1'b1; intf.out_ready = 1'b0;
        @(posedge clk); #1;
        intf.in_valid = 1'b0;
        chk({nm, " busy"}, intf.in_ready, 0);
        n = 0;
        while (!intf.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, " latency"}, n, W);
        repeat (hold) begin
            intf.a = 4'hC; intf.b = 4'hA; intf.bin = 1'b1; intf.in_valid = 1'b1;
            @(posedge clk); #1;
            chk({nm, " hold in_ready"}, intf.in_ready, 0);
            chk({nm, " hold out_valid"}, intf.out_valid, 1);
        end
        chk({nm, " diff"}, intf.diff, ed);
        chk({nm, " bout"}, intf.bout, eb);
        chk({nm, " ovf"}, intf.ovf, eo);
        intf.out_ready = 1'b1;
        @(posedge clk); #1;
        intf.out_ready = 1'b0;
        chk({nm, " drained"}, intf.out_valid, 0);
        chk({nm, " ready again"}, intf.in_ready, 1);
    endtask
    int hits, first;
    initial begin
        intf.in_valid = 1'b0; intf.a = '0; intf.b = '0; intf.bin = 1'b0; intf.out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst in_ready", intf.in_ready, 1);
        chk("rst out_valid", intf.out_valid, 0);
        chk("rst diff", intf.diff, 0);
        chk("rst bout", intf.bout, 0);
        chk("rst ovf", intf.ovf, 0);
        chk("model 5-3", ref_sub(4'd5, 4'd3, 1'b0), 6'b00_0010);
        chk("model 8-1", ref_sub(4'd8, 4'd1, 1'b0), 6'b10_0111);
        chk("model 7-F", ref_sub(4'd7, 4'hF, 1'b0), 6'b11_1000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        op(4'd5, 4'd3, 1'b0, 4'd2, 1'b0, 1'b0, 0, "5-3");
        op(4'd3, 4'd5, 1'b0, 4'hE, 1'b1, 1'b0, 0, "3-5");
        op(4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0, 0, "0-0-1");
        op(4'd8, 4'd1, 1'b0, 4'd7, 1'b0, 1'b1, 0, "8-1");
        op(4'd7, 4'hF, 1'b0, 4'd8, 1'b1, 1'b1, 0, "7-F");
        op(4'd3, 4'd5, 1'b0, 4'hE, 1'b1, 1'b0, 3, "hold 3-5");
        op(4'hC, 4'hA, 1'b1, 4'd1, 1'b0, 1'b0, 0, "C-A-1");
        intf.a = 4'd5; intf.b = 4'd3; intf.bin = 1'b0; intf.in_valid = 1'b1;
        @(posedge clk); #1;
        intf.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrun rst out_valid", intf.out_valid, 0);
        chk("midrun rst in_ready", intf.in_ready, 1);
        chk("midrun rst diff", intf.diff, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        op(4'd6, 4'd2, 1'b0, 4'd4, 1'b0, 1'b0, 0, "6-2");
        intf.out_ready = 1'b1; intf.a = 4'd9; intf.b = 4'd9; intf.bin = 1'b0; intf.in_valid = 1'b1;
        @(posedge clk); #1;
        intf.a = 4'hF; intf.b = 4'd0;
        hits = 0; first = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c == 6) intf.in_valid = 1'b0;
            if (intf.out_valid) begin
                hits++;
                if (hits == 1) begin
                    first = c;
                    chk("b2b 9-9 diff", intf.diff, 4'd0);
                    chk("b2b 9-9 bout", intf.bout, 0);
                end else begin
                    chk("b2b gap", c - first, 6);
                    chk("b2b F-0 diff", intf.diff, 4'hF);
                    chk("b2b F-0 bout", intf.bout, 0);
                end
            end
        end
        chk("b2b count", hits, 2);
        intf.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
